// File: rtl/audio_frame_sequencer.sv
// Frame-level controller for the audio effect chain: one codec read, one chain tick,
// a fixed pipeline wait, then one codec write (or a counted drop on timeout).
module audio_frame_sequencer #(
    parameter int unsigned PIPE_LATENCY = 4,
    parameter int unsigned TIMEOUT      = 2048,
    parameter int unsigned SW_WIDTH     = 10
) (
    input  logic                       CLOCK_50,
    input  logic                       resetn,
    input  logic [SW_WIDTH-1:0]        SW,
    input  logic                       audio_in_available,
    input  logic                       audio_out_allowed,
    input  logic signed [31:0]         audio_in_L,
    input  logic signed [31:0]         audio_in_R,
    input  logic signed [31:0]         chain_out_L,
    input  logic signed [31:0]         chain_out_R,
    output logic                       read_audio_in,
    output logic                       write_audio_out,
    output logic                       chain_tick,
    output logic signed [31:0]         chain_in_L,
    output logic signed [31:0]         chain_in_R,
    output logic signed [31:0]         audio_out_L,
    output logic signed [31:0]         audio_out_R,
    output logic [SW_WIDTH-1:0]        sw_cfg,
    output logic [15:0]                frame_count,
    output logic [7:0]                 drop_count,
    output logic                       busy
);

    localparam int unsigned CNT_MAX = (PIPE_LATENCY > TIMEOUT) ? PIPE_LATENCY : TIMEOUT;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX);
    localparam logic [CNT_W-1:0] PIPE_LAST    = CNT_W'(PIPE_LATENCY - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PROCESS  = 2'd1,
        WAIT_OUT = 2'd2,
        DONE     = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [SW_WIDTH-1:0]  sw_meta, sw_sync;

    logic                 read_d, write_d, tick_d;
    logic signed [31:0]   chain_in_l_d, chain_in_r_d, audio_out_l_d, audio_out_r_d;
    logic [SW_WIDTH-1:0]  sw_cfg_d;
    logic [15:0]          frame_count_d;
    logic [7:0]           drop_count_d;

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        read_d        = 1'b0;
        write_d       = 1'b0;
        tick_d        = 1'b0;
        chain_in_l_d  = chain_in_L;
        chain_in_r_d  = chain_in_R;
        audio_out_l_d = audio_out_L;
        audio_out_r_d = audio_out_R;
        sw_cfg_d      = sw_cfg;
        frame_count_d = frame_count;
        drop_count_d  = drop_count;

        unique case (state_q)
            IDLE: begin
                if (audio_in_available) begin
                    chain_in_l_d = audio_in_L;
                    chain_in_r_d = audio_in_R;
                    sw_cfg_d     = sw_sync;
                    read_d       = 1'b1;
                    tick_d       = 1'b1;
                    cnt_d        = '0;
                    state_d      = PROCESS;
                end
            end
            PROCESS: begin
                if (cnt_q == PIPE_LAST) begin
                    cnt_d   = '0;
                    state_d = WAIT_OUT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WAIT_OUT: begin
                // A write on the final timeout cycle takes priority over the drop.
                if (audio_out_allowed) begin
                    audio_out_l_d = chain_out_L;
                    audio_out_r_d = chain_out_R;
                    write_d       = 1'b1;
                    frame_count_d = frame_count + 16'd1;
                    state_d       = DONE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    drop_count_d = (drop_count == 8'hFF) ? drop_count : drop_count + 8'd1;
                    state_d      = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, synchroniser and output registers.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q         <= IDLE;
            cnt_q           <= '0;
            sw_meta         <= '0;
            sw_sync         <= '0;
            read_audio_in   <= 1'b0;
            write_audio_out <= 1'b0;
            chain_tick      <= 1'b0;
            chain_in_L      <= '0;
            chain_in_R      <= '0;
            audio_out_L     <= '0;
            audio_out_R     <= '0;
            sw_cfg          <= '0;
            frame_count     <= '0;
            drop_count      <= '0;
            busy            <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            sw_meta         <= SW;
            sw_sync         <= sw_meta;
            read_audio_in   <= read_d;
            write_audio_out <= write_d;
            chain_tick      <= tick_d;
            chain_in_L      <= chain_in_l_d;
            chain_in_R      <= chain_in_r_d;
            audio_out_L     <= audio_out_l_d;
            audio_out_R     <= audio_out_r_d;
            sw_cfg          <= sw_cfg_d;
            frame_count     <= frame_count_d;
            drop_count      <= drop_count_d;
            busy            <= (state_d != IDLE);
        end
    end

endmodule

// File: tb/tb_audio_frame_sequencer.sv
// Bench for audio_frame_sequencer: directed and randomized frames checked against
// a frame-timing model expressed as edge offsets from the capture edge.
module tb_audio_frame_sequencer;

    localparam int PL   = 4;
    localparam int TO   = 8;
    localparam int SW_W = 10;

    logic                CLOCK_50 = 1'b0;
    logic                resetn;
    logic [SW_W-1:0]     SW;
    logic                audio_in_available;
    logic                audio_out_allowed;
    logic signed [31:0]  audio_in_L, audio_in_R, chain_out_L, chain_out_R;
    logic                read_audio_in, write_audio_out, chain_tick, busy;
    logic signed [31:0]  chain_in_L, chain_in_R, audio_out_L, audio_out_R;
    logic [SW_W-1:0]     sw_cfg;
    logic [15:0]         frame_count;
    logic [7:0]          drop_count;

    audio_frame_sequencer #(.PIPE_LATENCY(PL), .TIMEOUT(TO), .SW_WIDTH(SW_W)) dut (
        .CLOCK_50(CLOCK_50), .resetn(resetn), .SW(SW),
        .audio_in_available(audio_in_available), .audio_out_allowed(audio_out_allowed),
        .audio_in_L(audio_in_L), .audio_in_R(audio_in_R),
        .chain_out_L(chain_out_L), .chain_out_R(chain_out_R),
        .read_audio_in(read_audio_in), .write_audio_out(write_audio_out),
        .chain_tick(chain_tick), .chain_in_L(chain_in_L), .chain_in_R(chain_in_R),
        .audio_out_L(audio_out_L), .audio_out_R(audio_out_R), .sw_cfg(sw_cfg),
        .frame_count(frame_count), .drop_count(drop_count), .busy(busy)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    int passes = 0;
    int checks = 0;

    // Reference state of the held outputs.
    logic [31:0]     m_in_l, m_in_r, m_out_l, m_out_r;
    logic [SW_W-1:0] m_cfg, m_sw;
    logic [15:0]     m_frame;
    int              m_drop;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) begin
            passes++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input bit e_rd, input bit e_wr, input bit e_busy);
        chk({tag, "/read"},  32'(read_audio_in),   32'(e_rd));
        chk({tag, "/tick"},  32'(chain_tick),      32'(e_rd));
        chk({tag, "/write"}, 32'(write_audio_out), 32'(e_wr));
        chk({tag, "/busy"},  32'(busy),            32'(e_busy));
        chk({tag, "/in_l"},  chain_in_L,  m_in_l);
        chk({tag, "/in_r"},  chain_in_R,  m_in_r);
        chk({tag, "/out_l"}, audio_out_L, m_out_l);
        chk({tag, "/out_r"}, audio_out_R, m_out_r);
        chk({tag, "/cfg"},   32'(sw_cfg),      32'(m_cfg));
        chk({tag, "/frame"}, 32'(frame_count), 32'(m_frame));
        chk({tag, "/drop"},  32'(drop_count),  32'(m_drop));
    endtask

    task automatic model_reset();
        m_in_l = '0; m_in_r = '0; m_out_l = '0; m_out_r = '0;
        m_cfg = '0; m_frame = '0; m_drop = 0;
    endtask

    // One frame starting from IDLE at a negedge. d = WAIT_OUT cycles with allowed low
    // before it rises; d >= TO means the codec never accepts and the sample is dropped.
    task automatic do_frame(input logic [31:0] l, input logic [31:0] r,
                            input logic [31:0] ol, input logic [31:0] orr,
                            input int d, input logic [SW_W-1:0] new_sw, input bit noisy);
        bit wr;
        int wr_edge, end_edge;
        wr       = (d < TO);
        wr_edge  = PL + 1 + d;
        end_edge = wr ? PL + 2 + d : PL + TO;
        audio_in_L = l; audio_in_R = r; chain_out_L = ol; chain_out_R = orr;
        audio_in_available = 1'b1;
        audio_out_allowed  = noisy ? 1'($urandom) : 1'b0;
        @(posedge CLOCK_50); @(negedge CLOCK_50);
        m_in_l = l; m_in_r = r; m_cfg = m_sw;
        check_outputs("capture", 1'b1, 1'b0, 1'b1);
        SW = new_sw;
        for (int i = 1; i <= end_edge; i++) begin
            audio_in_available = noisy ? 1'($urandom) : 1'b0;
            if (i < PL + 1) audio_out_allowed = noisy ? 1'($urandom) : 1'b0;
            else            audio_out_allowed = (i >= wr_edge);
            @(posedge CLOCK_50); @(negedge CLOCK_50);
            if (wr && i == wr_edge) begin
                m_out_l = ol; m_out_r = orr; m_frame = m_frame + 16'd1;
            end
            if (!wr && i == end_edge) m_drop = (m_drop == 255) ? 255 : m_drop + 1;
            check_outputs("frame", 1'b0, wr && i == wr_edge, i < end_edge);
        end
        m_sw = new_sw;
        audio_in_available = 1'b0;
        audio_out_allowed  = 1'b0;
    endtask

    initial begin
        resetn = 1'b0; SW = 10'h001; m_sw = 10'h001;
        audio_in_available = 1'b0; audio_out_allowed = 1'b0;
        audio_in_L = '0; audio_in_R = '0; chain_out_L = '0; chain_out_R = '0;
        model_reset();
        repeat (3) @(negedge CLOCK_50);
        check_outputs("reset_init", 1'b0, 1'b0, 1'b0);
        resetn = 1'b1;
        repeat (4) @(negedge CLOCK_50);
        check_outputs("idle", 1'b0, 1'b0, 1'b0);

        // Single frame, codec ready; SW changes to 0x00A mid-frame.
        do_frame(32'h0000_1234, 32'h0000_5678, 32'hFFFF_0000, 32'h0000_0001, 0, 10'h00A, 1'b0);
        chk("single/frame_count", 32'(frame_count), 32'd1);
        chk("single/cfg_held", 32'(sw_cfg), 32'h001);
        do_frame(32'h8000_0000, 32'h7FFF_FFFF, 32'h1357_9BDF, 32'h2468_ACE0, 2, 10'h3FF, 1'b0);
        chk("swchange/cfg_new", 32'(sw_cfg), 32'h00A);

        // Write on the last timeout cycle, then a genuine drop.
        do_frame(32'h1, 32'h2, 32'hCAFE_0001, 32'hCAFE_0002, TO - 1, 10'h155, 1'b0);
        chk("edge_write/drop", 32'(drop_count), 32'd0);
        do_frame(32'h3, 32'h4, 32'hDEAD_0001, 32'hDEAD_0002, TO, 10'h2AA, 1'b0);
        chk("timeout/drop", 32'(drop_count), 32'd1);

        // Reset in the middle of a frame discards it.
        audio_in_L = 32'h55; audio_in_available = 1'b1; audio_out_allowed = 1'b1;
        @(posedge CLOCK_50); @(negedge CLOCK_50);
        audio_in_available = 1'b0;
        @(posedge CLOCK_50); #2;
        resetn = 1'b0; #1;
        model_reset();
        check_outputs("reset_mid", 1'b0, 1'b0, 1'b0);
        @(negedge CLOCK_50); resetn = 1'b1; audio_out_allowed = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge CLOCK_50); @(negedge CLOCK_50);
            check_outputs("post_reset_idle", 1'b0, 1'b0, 1'b0);
        end

        // Back-to-back frames at the minimum period of PL+3 cycles.
        audio_in_L = 32'h0BAD_F00D; audio_in_R = 32'h0000_0042;
        chain_out_L = 32'h1111_2222; chain_out_R = 32'h3333_4444;
        audio_in_available = 1'b1; audio_out_allowed = 1'b1;
        for (int t = 0; t < 10 * (PL + 3); t++) begin
            @(posedge CLOCK_50); @(negedge CLOCK_50);
            chk("b2b/read",  32'(read_audio_in),   32'(t % (PL + 3) == 0));
            chk("b2b/tick",  32'(chain_tick),      32'(t % (PL + 3) == 0));
            chk("b2b/write", 32'(write_audio_out), 32'(t % (PL + 3) == PL + 1));
        end
        audio_in_available = 1'b0; audio_out_allowed = 1'b0;
        m_in_l = 32'h0BAD_F00D; m_in_r = 32'h42; m_out_l = 32'h1111_2222; m_out_r = 32'h3333_4444;
        m_cfg = m_sw; m_frame = 16'd10;
        check_outputs("b2b_end", 1'b0, 1'b0, 1'b0);

        // Randomized frames with noisy available/allowed during busy cycles.
        for (int n = 0; n < 40; n++) begin
            int gap;
            gap = int'($urandom_range(0, 3));
            for (int g = 0; g < gap; g++) begin
                @(posedge CLOCK_50); @(negedge CLOCK_50);
                check_outputs("rand_gap", 1'b0, 1'b0, 1'b0);
            end
            do_frame($urandom, $urandom, $urandom, $urandom, int'($urandom_range(0, TO + 2)),
                     SW_W'($urandom), 1'b1);
        end

        // Repeated timeouts saturate the drop counter.
        for (int n = 0; n < 300; n++)
            do_frame($urandom, $urandom, $urandom, $urandom, TO, m_sw, 1'b0);
        chk("saturate/drop", 32'(drop_count), 32'd255);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
